// File: rtl/spi_bus_arbiter_pkg.sv
// Shared types and helpers for the SPI bus arbiter (spi_bus_arbiter + rr_pick).
// Optional watchdog in the top is enabled by defining SPI_ARB_WDOG_EN.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_XFER = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_e;

  localparam int DEF_GAP_CYC     = 4;
  localparam int DEF_TIMEOUT_CYC = 1024;

  // Index width for n entries, never below 1 bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr (with wrap) wins.
import spi_arb_pkg::*;

module rr_pick #(
  parameter int N_REQ = 3,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    any   = |req;
    for (int i = 1; i <= N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Lock-based owner arbiter in front of a single SPI byte engine, one byte in flight.
// Define SPI_ARB_WDOG_EN to add the OWN-state watchdog that forces release.
import spi_arb_pkg::*;

module spi_bus_arbiter #(
  parameter int N_REQ       = 3,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_lock,
  input  logic [N_REQ-1:0]   req_trans,
  input  logic [8*N_REQ-1:0] req_tx,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   gnt_done,
  output logic [7:0]         rx_dout,
  output logic               busy,
  output logic               trans_req,
  output logic [7:0]         tx_dout,
  input  logic [7:0]         rx_din,
  input  logic               trans_done,
  output logic               wdog_err
);

  localparam int IW       = idx_w(N_REQ);
  localparam int GW       = idx_w(GAP_CYC);
  localparam int GAP_LOAD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  arb_state_e                 state_q, state_d;
  logic [N_REQ-1:0]           grant_q, grant_d;
  logic [IW-1:0]              own_q, own_d;
  logic [IW-1:0]              ptr_q, ptr_d;
  logic                       treq_q, treq_d;
  logic [7:0]                 tx_q, tx_d;
  logic [GW-1:0]              gap_q, gap_d;
  logic [N_REQ-1:0][7:0]      tx_lane;
  logic [N_REQ-1:0]           pick_gnt;
  logic [IW-1:0]              pick_idx;
  logic                       pick_any;
  logic                       lock_own, trans_own;

  assign tx_lane   = req_tx;
  assign lock_own  = req_lock[own_q];
  assign trans_own = req_trans[own_q];

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req (req_lock),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef SPI_ARB_WDOG_EN
  localparam int TW = idx_w(TIMEOUT_CYC);
  logic [TW-1:0] wd_q, wd_d;
  logic          wd_hit;
  assign wd_hit = (wd_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      own_q   <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      treq_q  <= 1'b0;
      tx_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      treq_q  <= treq_d;
      tx_q    <= tx_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    own_d    = own_q;
    ptr_d    = ptr_q;
    treq_d   = 1'b0;
    tx_d     = tx_q;
    gap_d    = gap_q;
    wdog_err = 1'b0;
`ifdef SPI_ARB_WDOG_EN
    wd_d     = '0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_gnt;
          own_d   = pick_idx;
          ptr_d   = pick_idx;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        // A strobe wins over a simultaneous unlock; release then waits for trans_done.
        if (trans_own) begin
          treq_d  = 1'b1;
          tx_d    = tx_lane[own_q];
          state_d = ST_XFER;
        end else if (!lock_own) begin
          grant_d = '0;
          if (GAP_CYC == 0) state_d = ST_IDLE;
          else begin
            state_d = ST_GAP;
            gap_d   = GW'(GAP_LOAD);
          end
`ifdef SPI_ARB_WDOG_EN
        end else if (wd_hit) begin
          wdog_err = 1'b1;
          grant_d  = '0;
          if (GAP_CYC == 0) state_d = ST_IDLE;
          else begin
            state_d = ST_GAP;
            gap_d   = GW'(GAP_LOAD);
          end
        end else begin
          wd_d = wd_q + 1'b1;
`endif
        end
      end
      ST_XFER: begin
        if (trans_done) begin
          if (lock_own) state_d = ST_OWN;
          else begin
            grant_d = '0;
            if (GAP_CYC == 0) state_d = ST_IDLE;
            else begin
              state_d = ST_GAP;
              gap_d   = GW'(GAP_LOAD);
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant     = grant_q;
  assign trans_req = treq_q;
  assign tx_dout   = tx_q;
  assign busy      = (state_q != ST_IDLE);
  assign rx_dout   = rx_din;
  assign gnt_done  = (state_q == ST_XFER && trans_done) ? grant_q : '0;

endmodule
